image_viewer_top: RTL and testbench

//  FPGA top level: reads 320x240 8bpp (RGB332) images from external async PSRAM and shows them 2x upscaled on 640x480@60 VGA.

---
 rtl/image_viewer_top.sv | 238 +++++++++++++++++++++++
 tb/tb_image_viewer_top.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_viewer_top.sv
// Image viewer: PSRAM RGB332 frames shown 2x upscaled on 640x480@60 VGA.
// Ports: ClkPort/btnC(async low reset), btnR/btnL step image, VGA out,
//   PSRAM bus (MemAdr/MemOE/data, read only), 7-seg digit 0, Led index.
//   Raster timing is parameterised; defaults give 640x480@60.
//   Define TEST_PATTERN_EN to show colour bars instead of memory.
module image_viewer_top #(
  parameter int NUM_IMAGES      = 4,
  parameter int IMG_WORDS       = 38400,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int H_ACTIVE        = 640,
  parameter int H_SYNC_START    = 656,
  parameter int H_SYNC_END      = 752,
  parameter int H_TOTAL         = 800,
  parameter int V_ACTIVE        = 480,
  parameter int V_SYNC_START    = 490,
  parameter int V_SYNC_END      = 492,
  parameter int V_TOTAL         = 525
) (
  input  logic        ClkPort,
  input  logic        btnC,
  input  logic        btnR,
  input  logic        btnL,
  output logic        Hsync,
  output logic        Vsync,
  output logic [2:0]  vgaRed,
  output logic [2:0]  vgaGreen,
  output logic [2:1]  vgaBlue,
  output logic        MemOE,
  output logic        MemWR,
  output logic        MemClk,
  output logic        RamAdv,
  output logic        RamCRE,
  output logic        RamCS,
  output logic        RamUB,
  output logic        RamLB,
  output logic [26:1] MemAdr,
  inout  wire  [15:0] data,
  output logic        An0,
  output logic        An1,
  output logic        An2,
  output logic        An3,
  output logic        Ca,
  output logic        Cb,
  output logic        Cc,
  output logic        Cd,
  output logic        Ce,
  output logic        Cf,
  output logic        Cg,
  output logic        Dp,
  output logic [1:0]  Led
);

  localparam int IXW = $clog2(NUM_IMAGES);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int WPL = H_ACTIVE / 4;

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_END);
  localparam logic [9:0] HL  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HPF = 10'(H_TOTAL - 4);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VSE = 10'(V_SYNC_END);
  localparam logic [9:0] VL  = 10'(V_TOTAL - 1);

  logic [1:0]     pre;
  logic [9:0]     hcount;
  logic [9:0]     vcount;
  logic [9:0]     nextV;
  logic           tick;
  logic           lastH;
  logic           lastV;
  logic           visible;
  logic [7:0]     pixel;
  logic [IXW-1:0] pendIdx;
  logic [IXW-1:0] dispIdx;
  logic [1:0]     syncA;
  logic [1:0]     syncB;
  logic [1:0]     deb;
  logic [1:0]     debQ;
  logic [1:0]     rise;
  logic [CW-1:0]  cnt [2];
  logic [6:0]     seg;

  assign tick    = pre == 2'd3;
  assign lastH   = hcount == HL;
  assign lastV   = vcount == VL;
  assign nextV   = lastV ? '0 : vcount + 10'd1;
  assign visible = (hcount < HA) && (vcount < VA);

  always_ff @(posedge ClkPort or negedge btnC) begin
    if (!btnC) begin
      pre    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pre <= pre + 2'd1;
      if (tick) begin
        if (lastH) begin
          hcount <= '0;
          vcount <= nextV;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

`ifndef TEST_PATTERN_EN
  logic        prefetch;
  logic        memOn;
  logic [8:0]  row;
  logic [25:0] col;
  logic [25:0] nextAdr;
  logic [15:0] dispWord;

  // Address of the next 4-pixel group; the last group of a line
  // points at word 0 of the following line.
  assign prefetch = hcount >= HPF;
  assign memOn    = (vcount < VA) || (lastV && prefetch);
  assign row      = prefetch ? nextV[9:1] : vcount[9:1];
  assign col      = prefetch ? '0 : 26'(hcount[9:2]) + 26'd1;
  assign nextAdr  = 26'(dispIdx) * 26'(IMG_WORDS)
                  + 26'(row) * 26'(WPL) + col;

  // Sampled on the group's last clock, 15 clocks after address settles.
  always_ff @(posedge ClkPort or negedge btnC) begin
    if (!btnC) begin
      dispWord <= '0;
    end else if (tick && (hcount[1:0] == 2'b11)) begin
      dispWord <= data;
    end
  end
`endif

  always_comb begin
`ifdef TEST_PATTERN_EN
    pixel = {hcount[9:7], vcount[8:6], hcount[6:5]};
`else
    pixel = hcount[1] ? dispWord[15:8] : dispWord[7:0];
`endif
  end

  always_ff @(posedge ClkPort or negedge btnC) begin
    if (!btnC) begin
      Hsync    <= 1'b1;
      Vsync    <= 1'b1;
      vgaRed   <= '0;
      vgaGreen <= '0;
      vgaBlue  <= '0;
      MemOE    <= 1'b1;
      MemAdr   <= '0;
    end else begin
      Hsync <= ~((hcount >= HSS) && (hcount < HSE));
      Vsync <= ~((vcount >= VSS) && (vcount < VSE));
      {vgaRed, vgaGreen, vgaBlue} <= visible ? pixel : 8'h00;
`ifdef TEST_PATTERN_EN
      MemOE  <= 1'b1;
      MemAdr <= '0;
`else
      MemOE  <= ~memOn;
      MemAdr <= memOn ? nextAdr : '0;
`endif
    end
  end

  // Bit 0 is btnR, bit 1 is btnL.
  always_ff @(posedge ClkPort or negedge btnC) begin
    if (!btnC) begin
      syncA  <= '0;
      syncB  <= '0;
      deb    <= '0;
      debQ   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      syncA <= {btnL, btnR};
      syncB <= syncA;
      debQ  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (syncB[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= syncB[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = deb & ~debQ;

  // Displayed index only changes at the start of vertical blanking.
  always_ff @(posedge ClkPort or negedge btnC) begin
    if (!btnC) begin
      pendIdx <= '0;
      dispIdx <= '0;
    end else begin
      unique case (rise)
        2'b01:   pendIdx <= pendIdx + IXW'(1);
        2'b10:   pendIdx <= pendIdx - IXW'(1);
        default: ;
      endcase
      if ((hcount == '0) && (vcount == VA)) begin
        dispIdx <= pendIdx;
      end
    end
  end

  always_comb begin
    seg = 7'b1111111;
    unique case (2'(dispIdx))
      2'd0: seg = 7'b0000001;
      2'd1: seg = 7'b1001111;
      2'd2: seg = 7'b0010010;
      2'd3: seg = 7'b0000110;
    endcase
  end

  assign {Ca, Cb, Cc, Cd, Ce, Cf, Cg} = seg;
  assign Dp     = 1'b1;
  assign An0    = 1'b0;
  assign An1    = 1'b1;
  assign An2    = 1'b1;
  assign An3    = 1'b1;
  assign Led    = 2'(dispIdx);
  assign MemWR  = 1'b1;
  assign MemClk = 1'b0;
  assign RamAdv = 1'b0;
  assign RamCRE = 1'b0;
  assign RamCS  = 1'b0;
  assign RamUB  = 1'b0;
  assign RamLB  = 1'b0;

endmodule

// File: tb/tb_image_viewer_top.sv
// Bench for image_viewer_top: small-raster and full-raster instances
// against a pixel-level reference model with random button activity.
module tb_image_viewer_top;

  localparam int DEB = 16;
  localparam int SHA = 32, SHSS = 36, SHSE = 40, SHT = 48;
  localparam int SVA = 8, SVSS = 9, SVSE = 11, SVT = 12;
  localparam int SIW = (SHA / 4) * (SVA / 2);
  localparam int FHA = 640, FHSS = 656, FHSE = 752, FHT = 800;
  localparam int FVA = 480, FVSS = 490, FVSE = 492, FVT = 525;
  localparam int FIW = 38400;
  localparam int LIM = 6000;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [7:0]  rgb;
    logic        oe;
    logic [25:0] adr;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic bR = 1'b0;
  logic bL = 1'b0;
  logic zero = 1'b0;

  logic hsS, vsS, oeS, wrS, mclkS, advS, creS, csS, ubS, lbS;
  logic [2:0] rS, gS;
  logic [2:1] bS;
  logic [26:1] adrS;
  wire  [15:0] dS;
  logic an0S, an1S, an2S, an3S, dpS;
  logic caS, cbS, ccS, cdS, ceS, cfS, cgS;
  logic [1:0] ledS;

  logic hsF, vsF, oeF, wrF, mclkF, advF, creF, csF, ubF, lbF;
  logic [2:0] rF, gF;
  logic [2:1] bF;
  logic [26:1] adrF;
  wire  [15:0] dF;
  logic an0F, an1F, an2F, an3F, dpF;
  logic caF, cbF, ccF, cdF, ceF, cfF, cgF;
  logic [1:0] ledF;

  // PSRAM model: word k holds k[15:0].
  assign dS = adrS[16:1];
  assign dF = adrF[16:1];

  int errors = 0;
  int checks = 0;
  int n = 0;
  int pendIdx = 0;
  int dispIdx = 0;
  int p, fs;
  exp_t eS, eF;
  logic [6:0] segTab [4] = '{7'b0000001, 7'b1001111,
                             7'b0010010, 7'b0000110};

  always #5 clk = ~clk;

  image_viewer_top #(
    .DEBOUNCE_CYCLES(DEB), .IMG_WORDS(SIW),
    .H_ACTIVE(SHA), .H_SYNC_START(SHSS),
    .H_SYNC_END(SHSE), .H_TOTAL(SHT),
    .V_ACTIVE(SVA), .V_SYNC_START(SVSS),
    .V_SYNC_END(SVSE), .V_TOTAL(SVT)
  ) dutS (
    .ClkPort(clk), .btnC(rstN), .btnR(bR), .btnL(bL),
    .Hsync(hsS), .Vsync(vsS),
    .vgaRed(rS), .vgaGreen(gS), .vgaBlue(bS),
    .MemOE(oeS), .MemWR(wrS), .MemClk(mclkS),
    .RamAdv(advS), .RamCRE(creS), .RamCS(csS),
    .RamUB(ubS), .RamLB(lbS), .MemAdr(adrS), .data(dS),
    .An0(an0S), .An1(an1S), .An2(an2S), .An3(an3S),
    .Ca(caS), .Cb(cbS), .Cc(ccS), .Cd(cdS),
    .Ce(ceS), .Cf(cfS), .Cg(cgS), .Dp(dpS), .Led(ledS)
  );

  image_viewer_top #(
    .DEBOUNCE_CYCLES(DEB)
  ) dutF (
    .ClkPort(clk), .btnC(rstN), .btnR(zero), .btnL(zero),
    .Hsync(hsF), .Vsync(vsF),
    .vgaRed(rF), .vgaGreen(gF), .vgaBlue(bF),
    .MemOE(oeF), .MemWR(wrF), .MemClk(mclkF),
    .RamAdv(advF), .RamCRE(creF), .RamCS(csF),
    .RamUB(ubF), .RamLB(lbF), .MemAdr(adrF), .data(dF),
    .An0(an0F), .An1(an1F), .An2(an2F), .An3(an3F),
    .Ca(caF), .Cb(cbF), .Cc(ccF), .Cd(cdF),
    .Ce(ceF), .Cf(cfF), .Cg(cgF), .Dp(dpF), .Led(ledF)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Expected outputs for pixel number p since reset.
  function automatic exp_t model(
    int p, int ha, int hss, int hse, int ht,
    int va, int vss, int vse, int vt, int iw, int idx);
    exp_t e;
    int f, h, v, w, a;
    f = p % (ht * vt);
    v = f / ht;
    h = f % ht;
    w = ha / 4;
    e.hs  = !(h >= hss && h < hse);
    e.vs  = !(v >= vss && v < vse);
    e.rgb = 8'h00;
    if (h < ha && v < va) begin
      a = idx * iw + (v / 2) * w + h / 4;
      e.rgb = (h % 4 < 2) ? a[7:0] : a[15:8];
    end
    e.oe  = 1'b1;
    e.adr = '0;
    if (v < va || (v == vt - 1 && h >= ht - 4)) begin
      e.oe = 1'b0;
      if (h >= ht - 4)
        e.adr = 26'(idx * iw + (((v + 1) % vt) / 2) * w);
      else
        e.adr = 26'(idx * iw + (v / 2) * w + h / 4 + 1);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rstN) n <= 0;
    else n <= n + 1;
  end

  always @(negedge clk) begin
    if (rstN && n > 0 && n % 4 == 2) begin
      p  = n / 4;
      fs = p % (SHT * SVT);
      if (fs == SVA * SHT) dispIdx = pendIdx;
      eS = model(p, SHA, SHSS, SHSE, SHT,
                 SVA, SVSS, SVSE, SVT, SIW, dispIdx);
      chk("syncS", {hsS, vsS}, {eS.hs, eS.vs});
      chk("rgbS", {rS, gS, bS}, eS.rgb);
      chk("memS", {oeS, adrS}, {eS.oe, eS.adr});
      chk("ledS", ledS, dispIdx);
      chk("segS", {caS, cbS, ccS, cdS, ceS, cfS, cgS},
          segTab[dispIdx]);
      chk("pinsS", {an0S, an1S, an2S, an3S, dpS, wrS,
                    mclkS, advS, creS, csS, ubS, lbS},
          12'b011111000000);
      if (p < 4 * FHT) begin
        eF = model(p, FHA, FHSS, FHSE, FHT,
                   FVA, FVSS, FVSE, FVT, FIW, 0);
        chk("syncF", {hsF, vsF}, {eF.hs, eF.vs});
        chk("rgbF", {rF, gF, bF}, eF.rgb);
        chk("memF", {oeF, adrF}, {eF.oe, eF.adr});
        chk("ledF", ledF, 0);
      end
    end
  end

  task automatic checkReset(input string tag);
    chk({tag, "Sync"}, {hsS, vsS, hsF, vsF}, 4'hF);
    chk({tag, "Rgb"}, {rS, gS, bS, rF, gF, bF}, 16'h0);
    chk({tag, "MemS"}, {oeS, adrS}, {1'b1, 26'd0});
    chk({tag, "MemF"}, {oeF, adrF}, {1'b1, 26'd0});
    chk({tag, "Led"}, {ledS, ledF}, 4'h0);
    chk({tag, "Seg"}, {caS, cbS, ccS, cdS, ceS, cfS, cgS},
        7'b0000001);
  endtask

  function automatic int lineS();
    return ((n / 4) % (SHT * SVT)) / SHT;
  endfunction

  // Wait for the start of line 1 of the next small-raster frame.
  task automatic waitFrame();
    int t;
    t = 0;
    while (lineS() == 1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    while (lineS() != 1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("frameWait", t < LIM, 1'b1);
    repeat ($urandom_range(0, 20)) @(negedge clk);
  endtask

  task automatic press(input bit r, input bit l, input int len);
    bR = r;
    bL = l;
    repeat (len) @(negedge clk);
    bR = 1'b0;
    bL = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    if (len > DEB + 4) begin
      if (r && !l) pendIdx = (pendIdx + 1) % 4;
      else if (l && !r) pendIdx = (pendIdx + 3) % 4;
    end
  endtask

  function automatic int hold();
    return $urandom_range(DEB + 8, DEB + 24);
  endfunction

  initial begin
    int k;
    #50;
    checkReset("rst0");
    #51;
    rstN = 1'b1;
    waitFrame(); press(1'b1, 1'b0, hold());
    waitFrame(); press(1'b0, 1'b1, hold());
    waitFrame(); press(1'b0, 1'b1, hold());
    waitFrame(); press(1'b1, 1'b1, hold());
    waitFrame(); press(1'b1, 1'b0, $urandom_range(2, 10));
    waitFrame(); press(1'b1, 1'b0, hold());
    for (int i = 0; i < 6; i++) begin
      waitFrame();
      k = $urandom_range(0, 3);
      case (k)
        0: press(1'b1, 1'b0, hold());
        1: press(1'b0, 1'b1, hold());
        2: press(1'b1, 1'b1, hold());
        default: press(1'($urandom_range(0, 1)), 1'b0,
                       $urandom_range(2, 10));
      endcase
      if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, hold());
    end
    waitFrame();
    repeat (SHT * 4 * 3) @(negedge clk);
    #1 rstN = 1'b0;
    pendIdx = 0;
    dispIdx = 0;
    #1 checkReset("rstMid");
    repeat (5) @(negedge clk);
    #1 rstN = 1'b1;
    waitFrame(); press(1'b1, 1'b0, hold());
    waitFrame();
    repeat (4 * 4 * FHT) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
